// File: rtl/bcd_to_bin_5.sv
`timescale 1ns/1ps
// Five-digit packed BCD to binary converter, one digit per cycle via acc*10+d.
// Latency 5 cycles from input handshake to out_valid; result held until out_ready.
module bcd_to_bin_5 #(
  parameter int DIGITS = 5,
  parameter int OUT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_bin,
  output logic                  out_ovf,
  output logic                  out_err
);

  localparam int IN_W  = 4 * DIGITS;
  localparam int ACC_W = OUT_W + 4;
  localparam int CW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IN_W-1:0]  shreg;
  logic [OUT_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             err;

  logic [3:0]       dig;
  logic             bad;
  logic [3:0]       d_use;
  logic [ACC_W-1:0] acc_w;
  logic [ACC_W-1:0] acc_next;
  logic             over;
  logic             ovf_n;
  logic             err_n;
  logic [OUT_W-1:0] acc_n;

  // The wide accumulator keeps the x10 product untruncated so overflow is seen exactly.
  always_comb begin
    dig      = shreg[IN_W-1 -: 4];
    bad      = (dig > 4'd9);
    d_use    = bad ? 4'd0 : dig;
    acc_w    = ACC_W'(acc);
    acc_next = (acc_w << 3) + (acc_w << 1) + ACC_W'(d_use);
    over     = |acc_next[ACC_W-1:OUT_W];
    err_n    = err | bad;
    ovf_n    = ovf | over;
    acc_n    = ovf_n ? {OUT_W{1'b1}} : acc_next[OUT_W-1:0];
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      out_bin <= '0;
      out_ovf <= 1'b0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_bcd;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
            state <= CONV;
          end
        end
        CONV: begin
          shreg <= shreg << 4;
          acc   <= acc_n;
          ovf   <= ovf_n;
          err   <= err_n;
          cnt   <= cnt + CW'(1);
          // An invalid digit dominates: the result is forced to zero and ovf is masked.
          if (cnt == LAST) begin
            state   <= DONE;
            out_err <= err_n;
            out_ovf <= ovf_n & ~err_n;
            out_bin <= err_n ? '0 : acc_n;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_5.sv
`timescale 1ns/1ps
// Self-checking bench for bcd_to_bin_5: directed cases plus a randomized stream against a decimal model.
module tb_bcd_to_bin_5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bin;
  logic        out_ovf;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_to_bin_5 #(.DIGITS(5), .OUT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_ovf(out_ovf), .out_err(out_err)
  );

  // Decimal reference: {err, ovf, bin}
  function automatic logic [17:0] ref_conv(input logic [19:0] b);
    int   v;
    bit   e;
    logic [3:0] d;
    v = 0;
    e = 0;
    for (int i = 4; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) e = 1;
      else v = v * 10 + int'(d);
    end
    if (e) return {2'b10, 16'h0000};
    if (v > 65535) return {2'b01, 16'hFFFF};
    return {2'b00, 16'(v)};
  endfunction

  function automatic logic [19:0] rand_bcd();
    logic [19:0] r;
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(0, 7) == 0) r[4*i +: 4] = 4'($urandom_range(0, 15));
      else r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // Single conversion with out_ready high; called at posedge+1 with the DUT idle.
  task automatic run_one(input logic [19:0] bcd, output int lat, output logic [15:0] bin,
                         output logic ovf, output logic err, output logic ir_done,
                         output logic ir_after);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bcd    = bcd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    bin     = out_bin;
    ovf     = out_ovf;
    err     = out_err;
    ir_done = in_ready;
    @(posedge clk); #1;
    ir_after = in_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_bin !== 16'h0) begin errors++; $display("FAIL reset_out_bin got %h want 0000", out_bin); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [15:0] bin; logic ovf, err, ird, ira;
    run_one(20'h12345, lat, bin, ovf, err, ird, ira);
    checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
    checks++; if (bin !== 16'h3039) begin errors++; $display("FAIL basic_bin got %h want 3039", bin); end
    checks++; if ({ovf, err} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b want 00", {ovf, err}); end
    checks++; if (ird !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %b want 0", ird); end
    checks++; if (ira !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after got %b want 1", ira); end
  endtask

  task automatic test_boundaries();
    logic [19:0] vin [7]  = '{20'h65535, 20'h65536, 20'h99999, 20'h00000, 20'h00009, 20'h12A45, 20'hF9999};
    logic [15:0] vbin [7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0009, 16'h0000, 16'h0000};
    logic [1:0]  vfl [7]  = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
    int lat; logic [15:0] bin; logic ovf, err, ird, ira;
    for (int i = 0; i < 7; i++) begin
      run_one(vin[i], lat, bin, ovf, err, ird, ira);
      checks++; if (lat != 5) begin errors++; $display("FAIL bound_latency in=%h got %0d want 5", vin[i], lat); end
      checks++; if (bin !== vbin[i]) begin errors++; $display("FAIL bound_bin in=%h got %h want %h", vin[i], bin, vbin[i]); end
      checks++; if ({ovf, err} !== vfl[i]) begin errors++; $display("FAIL bound_flags(ovf,err) in=%h got %b want %b", vin[i], {ovf, err}, vfl[i]); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bcd    = 20'h00042;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 5) begin errors++; $display("FAIL bp_latency got %0d want 5", lat); end
    in_valid = 1'b1;
    in_bcd   = 20'h11111;
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got %b want 1", i, out_valid); end
      checks++; if (out_bin !== 16'h002A) begin errors++; $display("FAIL bp_hold_bin cyc=%0d got %h want 002a", i, out_bin); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cyc=%0d got %b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_no_accept got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic [15:0] bin; logic ovf, err, ird, ira;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bcd    = 20'h54321;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_state got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    checks++; if ({out_bin, out_ovf, out_err} !== 18'h0) begin
      errors++; $display("FAIL midreset_outputs got bin=%h ovf=%b err=%b want 0", out_bin, out_ovf, out_err);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_valid got %0d pulses want 0", seen); end
    run_one(20'h00100, lat, bin, ovf, err, ird, ira);
    checks++; if (lat != 5 || bin !== 16'h0064 || {ovf, err} !== 2'b00) begin
      errors++; $display("FAIL midreset_next got lat=%0d bin=%h flags=%b want 5 0064 00", lat, bin, {ovf, err});
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] q[$];
    logic [17:0] exp;
    bit hs_in, hs_out;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (got < 20 && cyc < 3000) begin
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra_result got bin=%h with no pending input", out_bin);
        end else begin
          exp = q.pop_front();
          if ({out_err, out_ovf, out_bin} !== exp) begin
            errors++;
            $display("FAIL stream_result #%0d got err=%b ovf=%b bin=%h want err=%b ovf=%b bin=%h",
                     got, out_err, out_ovf, out_bin, exp[17], exp[16], exp[15:0]);
          end
        end
        got++;
      end
      if (hs_in) begin
        q.push_back(ref_conv(in_bcd));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (hs_in || !in_valid) begin
        if (sent < 20) begin
          in_valid = ($urandom_range(0, 2) != 0);
          in_bcd   = rand_bcd();
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 1) == 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (got != 20 || q.size() != 0) begin
      errors++; $display("FAIL stream_count got %0d results pending %0d want 20 0", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
